stream_pattern_gen: RTL
=======================

Name: stream_pattern_gen

Overview:
- Test-pattern source that drives two identical AXI4-Stream master outputs, intended to feed the dual-input stream comparator in loopback and link tests.
- Each lane produces the same PRBS31 word sequence from a common seed and advances independently under its own TREADY backpressure.
- Supports bounded or continuous runs, a stop request, and single-word error injection on lane 1 so the comparator's mismatch counting can be exercised.

Parameters:
- TDATA_WIDTH, 32: stream word width, 1..64.
- SEED, 32'h0000_0001: initial LFSR state, truncated to 31 bits; a zero seed is forced to 1.

Ports:
- clk  in  1: single clock for all logic.
- areset  in  1: asynchronous, active-high reset.
- start  in  1: one-cycle pulse; begins a run from IDLE or DONE.
- stop  in  1: one-cycle pulse; ends the run gracefully. Ignored outside RUN.
- n_words  in  32: words per lane for the run, sampled on start; 0 means continuous.
- inject_err  in  1: one-cycle pulse; arms inversion of bit 0 of the next fresh lane-1 word.
- M_AXIS_0_TDATA  out  TDATA_WIDTH: lane 0 data.
- M_AXIS_0_TVALID  out  1: lane 0 valid.
- M_AXIS_0_TREADY  in  1: lane 0 ready.
- M_AXIS_1_TDATA  out  TDATA_WIDTH: lane 1 data.
- M_AXIS_1_TVALID  out  1: lane 1 valid.
- M_AXIS_1_TREADY  in  1: lane 1 ready.
- busy  out  1: high while in RUN.
- done  out  1: high while in DONE.
- words_sent  out  32: lane 0 handshake count for the current run; wraps at 2^32.
- err_injected  out  32: count of corrupted lane-1 words accepted downstream; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, LFSRs loaded with SEED, injection flag clear.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when both lanes are finished.
  - DONE -> RUN on start.
  - There is no other transition.
- On start:
  - Latch n_words.
  - Reload both LFSRs with SEED.
  - Clear words_sent and the per-lane counters.
  - Each lane raises TVALID on the cycle after start, i.e. one cycle of latency, with the first word = seed-derived word 0.
- Word generation:
  - Next word = PRBS31 (x^31+x^28+1) advanced TDATA_WIDTH steps.
  - TDATA = the TDATA_WIDTH bits shifted out, MSB first.
  - TDATA is registered.
- A lane advances its LFSR and count only on TVALID & TREADY.
- AXIS holding rule: while TVALID=1 and TREADY=0, TDATA and TVALID are held stable. TVALID never drops before its handshake.
- Lane finished when:
  - n_words != 0 and lane count == n_words, or
  - stop is pending and the lane has no word outstanding.
- After a lane finishes, its TVALID stays 0.
- stop in RUN sets stop_pending. Each lane completes only its currently presented word, then finishes. stop_pending clears on entering DONE.
- inject_err arms a flag, in any state.
  - The flag applies to the next lane-1 word whose TVALID rises or which is freshly loaded after a handshake. A word already being held is never modified.
  - When that word handshakes: the flag clears and err_injected increments.
  - A second pulse while armed has no extra effect.
- Simultaneous events:
  - start and stop in the same cycle in IDLE/DONE: start wins, stop is ignored.
  - start in RUN is ignored.
  - Lane 0 and lane 1 finishing in different cycles: the FSM waits for both.
- areset mid-run: immediate return to reset values; TVALID drops asynchronously.

Optional Feature:
- Macro STREAM_PATTERN_GEN_COUNTER_MODE_EN.
- When defined:
  - Adds port mode in 1, sampled on start.
  - mode=1 selects an incrementing counter instead of PRBS: word k = SEED + k, modulo 2^TDATA_WIDTH.
  - Injection, counts, FSM and handshake behaviour are identical to PRBS mode.
- When undefined: no mode port; PRBS only.

Decomposition:
- Package stream_pattern_gen_pkg holds:
  - state enum typedef {IDLE, RUN, DONE};
  - PRBS31 tap constants;
  - function prbs31_advance(state, nbits) returning the next state and the output word.
- One sub-module, stream_pattern_gen_lane, instantiated twice. It holds the LFSR, the data/valid register, the per-lane count and the finished flag, plus an inject input used by lane 1 only.
- The top level holds the FSM, the injection flag and the status counters.

Test Plan:
- Counter mode, SEED=0, n_words=4, both TREADY=1, start -> each lane emits 0,1,2,3 on consecutive cycles from cycle+1; then done=1, words_sent=4.
- PRBS mode, SEED=1, n_words=8, lane 1 TREADY toggling 1,0,1,0 -> lane 1 TDATA matches lane 0 word-for-word; TDATA stable during stalls; done only after lane 1's eighth handshake.
- n_words=0, stop after 10 lane-0 handshakes with lane 0 stalled holding word 10 -> word 10 is still delivered when TREADY rises; both lanes then idle; done=1, words_sent=11.
- inject_err while lane 1 is stalled on word 3 (counter mode, SEED=0) -> word 3 goes out unmodified, word 4 goes out as 5 (bit 0 flipped); err_injected=1; lane 0 unaffected.
- areset asserted mid-run at word 5 -> TVALIDs, busy and counters go to 0 immediately; a new start restarts from the SEED word.
- start and stop pulsed together in IDLE -> run begins; stop ignored; all n_words=3 words are emitted.

Source files
------------

// File: rtl/stream_pattern_gen_pkg.sv
// rtl/stream_pattern_gen_pkg.sv - shared types and PRBS31 stepping for stream_pattern_gen
package stream_pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // x^31 + x^28 + 1 : feedback taps are bits 30 and 27 of the 31-bit state
    localparam int PRBS31_TAP_A = 30;
    localparam int PRBS31_TAP_B = 27;

    typedef struct packed {
        logic [30:0] state;
        logic [63:0] word;
    } prbs_res_t;

    // Step the LFSR nbits times; the first bit produced lands in word[nbits-1]
    function automatic prbs_res_t prbs31_advance(input logic [30:0] state, input int nbits);
        prbs_res_t r;
        logic      fb;
        r.state = state;
        r.word  = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < nbits) begin
                fb      = r.state[PRBS31_TAP_A] ^ r.state[PRBS31_TAP_B];
                r.state = {r.state[29:0], fb};
                r.word  = {r.word[62:0], fb};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_pattern_gen_lane.sv
// rtl/stream_pattern_gen_lane.sv - one AXIS pattern lane (macro STREAM_PATTERN_GEN_COUNTER_MODE_EN adds counter mode)
module stream_pattern_gen_lane
    import stream_pattern_gen_pkg::*;
#(
    parameter int          TDATA_WIDTH = 32,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   i_start,
    input  logic                   i_run,
    input  logic                   i_stop,
    input  logic                   i_inject,
`ifdef STREAM_PATTERN_GEN_COUNTER_MODE_EN
    input  logic                   i_mode,
`endif
    input  logic [31:0]            i_n_words,
    input  logic                   i_tready,
    output logic [TDATA_WIDTH-1:0] o_tdata,
    output logic                   o_tvalid,
    output logic [31:0]            o_count,
    output logic                   o_finished,
    output logic                   o_corrupt
);

    localparam logic [30:0] SEED31 = (SEED[30:0] == 31'd0) ? 31'd1 : SEED[30:0];

    logic [30:0]            r_lfsr;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic                   r_tvalid;
    logic [31:0]            r_count;
    logic                   r_finished;
    logic                   r_corrupt;

    logic                   w_fire;
    logic                   w_last;
    logic                   w_corrupt_next;
    logic [30:0]            w_lfsr_src;
    prbs_res_t              w_gen;
    logic [TDATA_WIDTH-1:0] w_word;

    assign w_fire     = r_tvalid & i_tready;
    assign w_lfsr_src = i_start ? SEED31 : r_lfsr;
    assign w_gen      = prbs31_advance(w_lfsr_src, TDATA_WIDTH);
    assign w_last     = ((i_n_words != 32'd0) && ((r_count + 32'd1) == i_n_words)) || i_stop;
    // A corrupted word that is handshaking now consumes the armed flag, so its successor stays clean
    assign w_corrupt_next = i_inject & ~(w_fire & r_corrupt);

`ifdef STREAM_PATTERN_GEN_COUNTER_MODE_EN
    localparam logic [TDATA_WIDTH-1:0] SEED_W = TDATA_WIDTH'(SEED);

    logic                   r_mode;
    logic [TDATA_WIDTH-1:0] r_ctr;
    logic                   w_mode;
    logic [TDATA_WIDTH-1:0] w_ctr_src;

    assign w_mode    = i_start ? i_mode : r_mode;
    assign w_ctr_src = i_start ? SEED_W : r_ctr;
    assign w_word    = w_mode ? w_ctr_src : w_gen.word[TDATA_WIDTH-1:0];

    // Counter-mode state: mode latched on start, counter advances with each loaded word
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_mode <= 1'b0;
            r_ctr  <= SEED_W;
        end else if (i_start || (i_run && w_fire && !w_last)) begin
            r_mode <= w_mode;
            r_ctr  <= w_ctr_src + 1'b1;
        end
    end
`else
    assign w_word = w_gen.word[TDATA_WIDTH-1:0];
`endif

    // Load word 0 on start, then present a fresh word after each handshake until the lane finishes
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_lfsr     <= SEED31;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_count    <= 32'd0;
            r_finished <= 1'b0;
            r_corrupt  <= 1'b0;
        end else if (i_start) begin
            r_lfsr     <= w_gen.state;
            r_tdata    <= w_word ^ TDATA_WIDTH'(w_corrupt_next);
            r_tvalid   <= 1'b1;
            r_count    <= 32'd0;
            r_finished <= 1'b0;
            r_corrupt  <= w_corrupt_next;
        end else if (i_run && w_fire) begin
            r_count <= r_count + 32'd1;
            if (w_last) begin
                r_tvalid   <= 1'b0;
                r_finished <= 1'b1;
                r_corrupt  <= 1'b0;
            end else begin
                r_lfsr    <= w_gen.state;
                r_tdata   <= w_word ^ TDATA_WIDTH'(w_corrupt_next);
                r_corrupt <= w_corrupt_next;
            end
        end
    end

    assign o_tdata    = r_tdata;
    assign o_tvalid   = r_tvalid;
    assign o_count    = r_count;
    assign o_finished = r_finished;
    assign o_corrupt  = r_corrupt;

endmodule

// File: rtl/stream_pattern_gen.sv
// rtl/stream_pattern_gen.sv - dual-lane AXIS PRBS31 test-pattern source (macro STREAM_PATTERN_GEN_COUNTER_MODE_EN adds mode port)
module stream_pattern_gen
    import stream_pattern_gen_pkg::*;
#(
    parameter int          TDATA_WIDTH = 32,
    parameter logic [31:0] SEED        = 32'h0000_0001
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [31:0]            n_words,
`ifdef STREAM_PATTERN_GEN_COUNTER_MODE_EN
    input  logic                   mode,
`endif
    input  logic                   inject_err,
    output logic [TDATA_WIDTH-1:0] M_AXIS_0_TDATA,
    output logic                   M_AXIS_0_TVALID,
    input  logic                   M_AXIS_0_TREADY,
    output logic [TDATA_WIDTH-1:0] M_AXIS_1_TDATA,
    output logic                   M_AXIS_1_TVALID,
    input  logic                   M_AXIS_1_TREADY,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            words_sent,
    output logic [31:0]            err_injected
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_stop_pending;
    logic        r_inj_armed;
    logic [31:0] r_n_words;
    logic [31:0] r_err_cnt;

    logic        w_start;
    logic        w_run;
    logic        w_stop_eff;
    logic        w_fin0;
    logic        w_fin1;
    logic        w_corrupt1;
    logic        w_inj_clear;
    logic [31:0] w_count0;

    assign w_run       = (r_state == RUN);
    assign w_start     = start & ~w_run;
    assign w_stop_eff  = r_stop_pending | (stop & w_run);
    assign w_inj_clear = M_AXIS_1_TVALID & M_AXIS_1_TREADY & w_corrupt1;

    // State register
    always_ff @(posedge clk or posedge areset) begin
        if (areset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state: a run ends only once both lanes have finished
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_fin0 && w_fin1) w_state_next = DONE;
            DONE:    if (start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    // Run control: latch word budget on start, hold stop request until DONE
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_n_words      <= 32'd0;
            r_stop_pending <= 1'b0;
        end else begin
            if (w_start) r_n_words <= n_words;
            if (w_run && w_state_next == DONE) r_stop_pending <= 1'b0;
            else if (w_run && stop)            r_stop_pending <= 1'b1;
        end
    end

    // Error injection: arm on pulse, disarm and count when the corrupted lane-1 word is accepted
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_inj_armed <= 1'b0;
            r_err_cnt   <= 32'd0;
        end else begin
            r_inj_armed <= r_inj_armed ? ~w_inj_clear : inject_err;
            if (w_inj_clear) r_err_cnt <= r_err_cnt + 32'd1;
        end
    end

    stream_pattern_gen_lane #(.TDATA_WIDTH(TDATA_WIDTH), .SEED(SEED)) u_lane0 (
        .clk        (clk),
        .areset     (areset),
        .i_start    (w_start),
        .i_run      (w_run),
        .i_stop     (w_stop_eff),
        .i_inject   (1'b0),
`ifdef STREAM_PATTERN_GEN_COUNTER_MODE_EN
        .i_mode     (mode),
`endif
        .i_n_words  (r_n_words),
        .i_tready   (M_AXIS_0_TREADY),
        .o_tdata    (M_AXIS_0_TDATA),
        .o_tvalid   (M_AXIS_0_TVALID),
        .o_count    (w_count0),
        .o_finished (w_fin0),
        .o_corrupt  ()
    );

    stream_pattern_gen_lane #(.TDATA_WIDTH(TDATA_WIDTH), .SEED(SEED)) u_lane1 (
        .clk        (clk),
        .areset     (areset),
        .i_start    (w_start),
        .i_run      (w_run),
        .i_stop     (w_stop_eff),
        .i_inject   (r_inj_armed),
`ifdef STREAM_PATTERN_GEN_COUNTER_MODE_EN
        .i_mode     (mode),
`endif
        .i_n_words  (r_n_words),
        .i_tready   (M_AXIS_1_TREADY),
        .o_tdata    (M_AXIS_1_TDATA),
        .o_tvalid   (M_AXIS_1_TVALID),
        .o_count    (),
        .o_finished (w_fin1),
        .o_corrupt  (w_corrupt1)
    );

    assign busy         = (r_state == RUN);
    assign done         = (r_state == DONE);
    assign words_sent   = w_count0;
    assign err_injected = r_err_cnt;

endmodule
